// File: rtl/dvma_arbiter_n.sv
// Purpose : N-channel DVMA bus controller. Obtains the 68010 bus through
//           p_br/p_bg/p_back, grants one channel at a time, drives p_as/fc1
//           for the granted cycle with an ack timeout, and breaks system-bus
//           deadlock with xhalt/xberr.
// Latency : req -> p_br 1 cycle; p_bg&~sas -> grant/p_as 1 cycle;
//           sack -> done 1 cycle; timeout abort TMO_CYC cycles after p_as rises.
// Backpressure: a granted channel holds req until done/abort; the bus is not
//           released (p_back stays high) until the bus strobe sas drops.
//
// Optional feature macro: ROUND_ROBIN_EN
//   undefined : fixed priority, the lowest-index requester wins.
//   defined   : rotating priority from ptr, ptr = win+1 after each cycle;
//               channel 0 (refresh) always wins when it requests.
//
// Ports (all active-high):
//   c100        clock              reset      synchronous reset
//   req[NCH]    channel requests   supv[NCH]  channel supervisor flag -> fc1
//   p_bg        CPU bus grant      sas        bus address strobe (bus busy)
//   sack        slave acknowledge  sysb       system bus held by foreign master
//   ben         on-board bus enable
//   p_br        bus request        p_back     bus grant ack / p_as,fc1 enable
//   p_as        DVMA strobe        fc1        function code bit 1
//   grant[NCH]  one-hot owner      done/abort[NCH] one-cycle completion pulses
//   xhalt/xberr deadlock recovery to the CPU

module dvma_arbiter_n #(
  parameter int NCH     = 4,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 200
) (
  input  logic           c100,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] supv,
  input  logic           p_bg,
  input  logic           sas,
  input  logic           sack,
  input  logic           sysb,
  input  logic           ben,
  output logic           p_br,
  output logic           p_back,
  output logic           p_as,
  output logic           fc1,
  output logic [NCH-1:0] grant,
  output logic [NCH-1:0] done,
  output logic [NCH-1:0] abort,
  output logic           xhalt,
  output logic           xberr
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    win, win_nx;
  logic [IW-1:0]    pick;
  logic [TMO_W-1:0] cnt, cnt_nx;
  logic [NCH-1:0]   grant_nx, done_nx, abort_nx;
  logic             xhalt_nx, xberr_nx;
  logic             any_req, any_other, tmo_hit, dl_cond;

`ifdef ROUND_ROBIN_EN
  logic [IW-1:0]    ptr, ptr_nx;
  int               slot;
`endif

  assign any_req   = |req;
  // The owner's own request level is stale on the cycle the bus is released.
  assign any_other = |(req & ~grant);
  assign tmo_hit   = (cnt == TMO_W'(TMO_CYC - 1));

  // Winner selection among the current requesters.
  always_comb begin
    pick = '0;
`ifdef ROUND_ROBIN_EN
    slot = 0;
    // Scan downward so the requester closest to ptr is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      slot = int'(ptr) + i;
      if (slot >= NCH) slot = slot - NCH;
      if (req[IW'(slot)]) pick = IW'(slot);
    end
    // Refresh must never be starved by the rotation.
    if (req[0]) pick = '0;
`else
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[IW'(i)]) pick = IW'(i);
    end
`endif
  end

  // Bus ownership sequencing.
  always_comb begin
    state_nx = state;
    win_nx   = win;
    grant_nx = grant;
    cnt_nx   = cnt;
    done_nx  = '0;
    abort_nx = '0;
    p_br     = 1'b0;
    p_back   = 1'b0;
    p_as     = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) state_nx = REQ;
      end

      REQ: begin
        p_br = 1'b1;
        if (p_bg && !sas && any_req) begin
          win_nx   = pick;
          grant_nx = NCH'(1) << pick;
          cnt_nx   = '0;
          state_nx = OWN;
        end else if (!any_req) begin
          state_nx = IDLE;
        end
      end

      OWN: begin
        p_back = 1'b1;
        p_as   = 1'b1;
        // sack takes precedence over a coincident timeout.
        if (sack) begin
          done_nx  = grant;
          state_nx = REL;
        end else if (tmo_hit) begin
          abort_nx = grant;
          state_nx = REL;
        end else begin
          cnt_nx = cnt + TMO_W'(1);
        end
      end

      REL: begin
        // Keep p_back until the last strobe on the bus has gone away.
        p_back = 1'b1;
        if (!sas) begin
          grant_nx = '0;
          state_nx = any_other ? REQ : IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // fc1 is only meaningful while p_back enables the DVMA drivers.
  assign fc1 = p_back & supv[win];

`ifdef ROUND_ROBIN_EN
  always_comb begin
    ptr_nx = ptr;
    if ((|done_nx) || (|abort_nx)) begin
      ptr_nx = (win == IW'(NCH - 1)) ? '0 : win + IW'(1);
    end
  end
`endif

  // Deadlock: we want the bus while a foreign master holds the system bus.
  // xhalt first; xberr one cycle later if it persists. xberr is held while
  // a strobe is still on the bus, and xhalt always covers xberr.
  assign dl_cond  = ((state == REQ) && sysb && (|req[NCH-1:1])) ||
                    (req[0] && !ben && sysb);
  assign xberr_nx = (xhalt && dl_cond) || (xberr && sas);
  assign xhalt_nx = dl_cond || xberr_nx;

  always_ff @(posedge c100) begin
    if (reset) begin
      state <= IDLE;
      win   <= '0;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
      abort <= '0;
      xhalt <= 1'b0;
      xberr <= 1'b0;
    end else begin
      state <= state_nx;
      win   <= win_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      done  <= done_nx;
      abort <= abort_nx;
      xhalt <= xhalt_nx;
      xberr <= xberr_nx;
    end
  end

`ifdef ROUND_ROBIN_EN
  always_ff @(posedge c100) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nx;
  end
`endif

endmodule

// File: tb/tb_dvma_arbiter_n.sv
// Purpose : self-checking bench for dvma_arbiter_n (directed scenarios plus
//           randomized traffic against a transaction-level model).
// Latency : n/a.
// Backpressure: requests are dropped only after the DUT reports done/abort.

module tb_dvma_arbiter_n;

  localparam int NCH     = 4;
  localparam int TMO_W   = 8;
  localparam int TMO_CYC = 200;
  localparam int IW      = $clog2(NCH);

  logic           c100  = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] req   = '0;
  logic [NCH-1:0] supv  = '0;
  logic           p_bg  = 1'b0;
  logic           sas   = 1'b0;
  logic           sack  = 1'b0;
  logic           sysb  = 1'b0;
  logic           ben   = 1'b1;
  logic           p_br, p_back, p_as, fc1, xhalt, xberr;
  logic [NCH-1:0] grant, done, abort;

  dvma_arbiter_n #(.NCH(NCH), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
    .c100(c100), .reset(reset), .req(req), .supv(supv), .p_bg(p_bg),
    .sas(sas), .sack(sack), .sysb(sysb), .ben(ben), .p_br(p_br),
    .p_back(p_back), .p_as(p_as), .fc1(fc1), .grant(grant), .done(done),
    .abort(abort), .xhalt(xhalt), .xberr(xberr)
  );

  always #5 c100 = ~c100;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge c100);
  endtask

  // ---------------- reference model ----------------
  // Bus ownership described by what is visible: who owns the bus, whether
  // we are asking for it, strobing, or still holding it; plus age of the
  // current strobe in cycles.
  int             m_owner  = -1;
  bit             m_br     = 1'b0;
  bit             m_hold   = 1'b0;
  bit             m_strobe = 1'b0;
  int             m_age    = 0;
  int             m_ptr    = 0;
  logic [NCH-1:0] m_done   = '0;
  logic [NCH-1:0] m_abort  = '0;
  bit             m_xhalt  = 1'b0;
  bit             m_xberr  = 1'b0;

  function automatic logic [NCH-1:0] onehot(input int i);
    logic [NCH-1:0] v;
    v = '0;
    v[IW'(i)] = 1'b1;
    return v;
  endfunction

  function automatic int winner(input logic [NCH-1:0] r, input int p);
    int idx;
`ifdef ROUND_ROBIN_EN
    if (r[0]) return 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (p + k) % NCH;
      if (r[IW'(idx)]) return idx;
    end
`else
    idx = p;
    for (int k = 0; k < NCH; k++) begin
      if (r[IW'(k)]) return k;
    end
`endif
    return -1;
  endfunction

  always @(posedge c100) begin
    bit cond, nb, nh;
    if (reset) begin
      m_owner = -1; m_br = 0; m_hold = 0; m_strobe = 0; m_age = 0; m_ptr = 0;
      m_done = '0; m_abort = '0; m_xhalt = 0; m_xberr = 0;
    end else begin
      cond = (m_br && sysb && (req[NCH-1:1] != '0)) || (req[0] && !ben && sysb);
      nb   = (m_xhalt && cond) || (m_xberr && sas);
      nh   = cond || nb;
      m_done  = '0;
      m_abort = '0;
      if (m_strobe) begin
        m_age++;
        if (sack) begin
          m_done = onehot(m_owner); m_strobe = 0; m_ptr = (m_owner + 1) % NCH;
        end else if (m_age == TMO_CYC) begin
          m_abort = onehot(m_owner); m_strobe = 0; m_ptr = (m_owner + 1) % NCH;
        end
      end else if (m_hold) begin
        if (!sas) begin
          m_br    = (req & ~onehot(m_owner)) != '0;
          m_hold  = 0;
          m_owner = -1;
        end
      end else if (m_br) begin
        if (req == '0) m_br = 0;
        else if (p_bg && !sas) begin
          m_owner = winner(req, m_ptr);
          m_br = 0; m_hold = 1; m_strobe = 1; m_age = 0;
        end
      end else if (req != '0) begin
        m_br = 1;
      end
      m_xhalt = nh;
      m_xberr = nb;
    end
  end

  // Per-cycle comparison, away from both clock edges.
  always @(negedge c100) begin
    #2;
    if (checking) begin
      chk("p_br",   p_br,   m_br);
      chk("p_back", p_back, m_hold);
      chk("p_as",   p_as,   m_strobe);
      chk("fc1",    fc1,    (m_owner >= 0) ? supv[IW'(m_owner)] : 1'b0);
      chk("grant",  grant,  (m_owner >= 0) ? onehot(m_owner) : '0);
      chk("done",   done,   m_done);
      chk("abort",  abort,  m_abort);
      chk("xhalt",  xhalt,  m_xhalt);
      chk("xberr",  xberr,  m_xberr);
      chk("br_while_back", p_br & p_back, 1'b0);
    end
  end

  task automatic idle_inputs();
    req = '0; supv = '0; p_bg = 0; sas = 0; sack = 0; sysb = 0; ben = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc(1);
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NCH-1:0] t2_exp [3];
    int ascnt, ng, n, mode;
    bit saw_done;

    cyc(2);
    checking = 1;
    chk("rst_outs", {p_br, p_back, p_as, fc1, grant, done, abort, xhalt, xberr}, '0);
    reset = 0;

    // T1: single channel, p_bg two cycles after p_br, sack after 3 strobe cycles.
    req = 4'b0100;
    cyc(1); chk("t1_br", p_br, 1);
    cyc(1); p_bg = 1;
    cyc(1); chk("t1_grant", grant, 4'b0100); chk("t1_as", p_as, 1); p_bg = 0;
    ascnt = 1;
    cyc(1); ascnt += int'(p_as);
    cyc(1); ascnt += int'(p_as); sack = 1; sas = 1;
    cyc(1); chk("t1_as_len", ascnt, 3); chk("t1_done", done, 4'b0100);
    chk("t1_back_hold", p_back, 1); sack = 0; req = '0;
    cyc(1); chk("t1_back_sas", p_back, 1); sas = 0;
    cyc(1); chk("t1_back_drop", p_back, 0); chk("t1_grant_clr", grant, 4'b0000);

    // T2: grant order with several requests held.
    do_reset();
`ifdef ROUND_ROBIN_EN
    req = 4'b1010;
    t2_exp[0] = 4'b0010; t2_exp[1] = 4'b1000; t2_exp[2] = 4'b0010;
`else
    req = 4'b1011;
    t2_exp[0] = 4'b0001; t2_exp[1] = 4'b0001; t2_exp[2] = 4'b0001;
`endif
    p_bg = 1; sack = 1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 3; i++) begin
      cyc(1);
      if (p_as) begin
        chk($sformatf("t2_grant%0d", ng), grant, t2_exp[ng]);
        ng++;
      end
    end
    chk("t2_grant_count", ng, 3);

    // T3: no sack, abort TMO_CYC cycles after p_as rises.
    do_reset();
    req = 4'b0010; p_bg = 1;
    for (int i = 0; i < 10 && !p_as; i++) cyc(1);
    chk("t3_as_rise", p_as, 1);
    p_bg = 0;
    n = 0; saw_done = 0;
    for (int i = 0; i < 300 && abort == '0; i++) begin
      cyc(1); n++;
      if (done != '0) saw_done = 1;
    end
    chk("t3_abort_delay", n, TMO_CYC);
    chk("t3_abort", abort, 4'b0010);
    chk("t3_no_done", saw_done, 0);
    chk("t3_in_rel", p_back, 1);
    req = '0;
    cyc(1); chk("t3_back_drop", p_back, 0);

    // T5: sack on the timeout cycle itself.
    do_reset();
    req = 4'b0010; p_bg = 1;
    for (int i = 0; i < 10 && !p_as; i++) cyc(1);
    chk("t5_as_rise", p_as, 1);
    p_bg = 0;
    cyc(TMO_CYC - 1); chk("t5_as_last", p_as, 1); sack = 1;
    cyc(1); chk("t5_done", done, 4'b0010); chk("t5_abort", abort, 4'b0000);
    sack = 0; req = '0;

    // T4: deadlock escalation and recovery.
    do_reset();
    req = 4'b0010; sysb = 1;
    cyc(1); chk("t4_xhalt0", xhalt, 0);
    cyc(1); chk("t4_xhalt1", xhalt, 1); chk("t4_xberr0", xberr, 0);
    cyc(1); chk("t4_xberr1", xberr, 1); chk("t4_xhalt_hold", xhalt, 1);
    sysb = 0; sas = 0;
    cyc(2); chk("t4_clear", {xhalt, xberr}, 2'b00);
    req = '0;

    // T6: reset in the middle of a cycle.
    do_reset();
    req = 4'b0001; supv = 4'b0001; p_bg = 1;
    for (int i = 0; i < 10 && !p_as; i++) cyc(1);
    chk("t6_fc1", fc1, 1);
    reset = 1;
    cyc(1);
    chk("t6_rst_outs", {p_br, p_back, p_as, fc1, grant, done, abort, xhalt, xberr}, '0);
    reset = 0; p_bg = 0;
    cyc(1); chk("t6_br_again", p_br, 1);

    // Randomized traffic.
    do_reset();
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 300 == 0) mode = $urandom_range(0, 2);
      req = req & ~(done | abort);
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 7) == 0) req[k] = 1'b1;
        else if ($urandom_range(0, 63) == 0) req[k] = 1'b0;
      end
      supv  = NCH'($urandom);
      p_bg  = ($urandom_range(0, 3) != 0);
      sas   = ($urandom_range(0, 3) == 0);
      sack  = (mode == 0) ? ($urandom_range(0, 1) == 0) :
              (mode == 1) ? 1'b0 : ($urandom_range(0, 9) == 0);
      sysb  = ($urandom_range(0, 15) == 0);
      ben   = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 0;
    idle_inputs();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
